// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle control sequencer:
// state encoding, condition codes, PSR flag positions, opcode/ext
// constants and the pc_src / reg_write_src mux encodings.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ALU,
    S_LSH,
    S_LUI,
    S_LOAD,
    S_LOAD_WB,
    S_STORE,
    S_JAL,
    S_JCOND,
    S_BCOND,
    S_WRITE,
    S_HALT
  } state_t;

  // Condition codes (A_index field of Bcond/Jcond)
  localparam logic [3:0] CC_EQ = 4'h0;  // Z
  localparam logic [3:0] CC_NE = 4'h1;  // !Z
  localparam logic [3:0] CC_CS = 4'h2;  // C
  localparam logic [3:0] CC_CC = 4'h3;  // !C
  localparam logic [3:0] CC_HI = 4'h4;  // L
  localparam logic [3:0] CC_LS = 4'h5;  // !L
  localparam logic [3:0] CC_GT = 4'h6;  // N
  localparam logic [3:0] CC_LE = 4'h7;  // !N
  localparam logic [3:0] CC_FS = 4'h8;  // F
  localparam logic [3:0] CC_FC = 4'h9;  // !F
  localparam logic [3:0] CC_LO = 4'hA;  // !L & !Z
  localparam logic [3:0] CC_HS = 4'hB;  // L | Z
  localparam logic [3:0] CC_LT = 4'hC;  // !N & !Z
  localparam logic [3:0] CC_GE = 4'hD;  // N | Z
  localparam logic [3:0] CC_UC = 4'hE;  // always

  // PSR flag bit positions
  localparam int unsigned PSR_C = 0;
  localparam int unsigned PSR_L = 2;
  localparam int unsigned PSR_F = 5;
  localparam int unsigned PSR_Z = 6;
  localparam int unsigned PSR_N = 7;

  // Opcode / extended opcode constants
  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_MEM    = 4'b0100;  // LOAD/STORE/JAL/JCOND family
  localparam logic [3:0] OP_LSH    = 4'b1000;
  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_LUI    = 4'b1111;
  localparam logic [3:0] OP_CMP    = 4'b1011;  // also the CMP ext code
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STORE = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // pc_src encodings
  localparam logic [1:0] PC_SRC_ALU = 2'b00;
  localparam logic [1:0] PC_SRC_REG = 2'b01;
  localparam logic [1:0] PC_SRC_INC = 2'b10;

  // reg_write_src encodings
  localparam logic [1:0] RWS_ALU = 2'b00;
  localparam logic [1:0] RWS_MEM = 2'b01;
  localparam logic [1:0] RWS_PC1 = 2'b10;

endpackage

// File: rtl/cpu_sequencer_cond_eval.sv
// cond_eval: combinational branch-condition evaluator.
//   i_cond  [3:0]      condition code
//   i_psr   [WIDTH-1:0] processor status register
//   o_taken            condition holds (undefined codes are never taken)
module cond_eval
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [3:0]       i_cond,
  input  logic [WIDTH-1:0] i_psr,
  output logic             o_taken
);

  logic w_c, w_l, w_f, w_z, w_n;
  logic w_unused_psr;

  assign w_c = i_psr[PSR_C];
  assign w_l = i_psr[PSR_L];
  assign w_f = i_psr[PSR_F];
  assign w_z = i_psr[PSR_Z];
  assign w_n = i_psr[PSR_N];

  // Only five PSR bits carry flags; the rest are intentionally ignored.
  assign w_unused_psr = ^i_psr;

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      CC_EQ:   o_taken = w_z;
      CC_NE:   o_taken = ~w_z;
      CC_CS:   o_taken = w_c;
      CC_CC:   o_taken = ~w_c;
      CC_HI:   o_taken = w_l;
      CC_LS:   o_taken = ~w_l;
      CC_GT:   o_taken = w_n;
      CC_LE:   o_taken = ~w_n;
      CC_FS:   o_taken = w_f;
      CC_FC:   o_taken = ~w_f;
      CC_LO:   o_taken = ~w_l & ~w_z;
      CC_HS:   o_taken = w_l | w_z;
      CC_LT:   o_taken = ~w_n & ~w_z;
      CC_GE:   o_taken = w_n | w_z;
      CC_UC:   o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle control FSM for the 16-bit datapath.
// Inputs : clk, reset (async, active-high), op_code, ext_op_code,
//          A_index (condition code), psr_flags, mem_ready.
// Outputs: mem_req / write_to_memory / loading / storing (memory),
//          instruction_en, alu_A_src, alu_B_src, alu_cont, reg_write,
//          reg_write_src, pc_en, pc_src, illegal, halted.
// Every memory access handshakes on mem_req/mem_ready; a wait longer
// than MEM_TIMEOUT cycles (0 = no limit) parks the core in HALT.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned ALU_CONT_BITS    = 6,
  parameter int unsigned REG_BITS         = 4,
  parameter int unsigned OP_CODE_BITS     = 4,
  parameter int unsigned EXT_OP_CODE_BITS = 4,
  parameter int unsigned MEM_TIMEOUT      = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [OP_CODE_BITS-1:0]     op_code,
  input  logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
  input  logic [REG_BITS-1:0]         A_index,
  input  logic [WIDTH-1:0]            psr_flags,
  input  logic                        mem_ready,
  output logic                        mem_req,
  output logic                        write_to_memory,
  output logic                        loading,
  output logic                        storing,
  output logic                        instruction_en,
  output logic                        alu_A_src,
  output logic                        alu_B_src,
  output logic [ALU_CONT_BITS-1:0]    alu_cont,
  output logic                        reg_write,
  output logic [1:0]                  reg_write_src,
  output logic                        pc_en,
  output logic [1:0]                  pc_src,
  output logic                        illegal,
  output logic                        halted
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t           r_state, w_next, w_exec_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [1:0]       r_wr_pc_src;
  logic             w_taken, w_wait_state, w_waiting, w_timeout, w_imm;

  cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
    .i_cond  (A_index[3:0]),
    .i_psr   (psr_flags),
    .o_taken (w_taken)
  );

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_STORE);
  assign w_waiting    = w_wait_state && !mem_ready;
  assign w_timeout    = (MEM_TIMEOUT != 0) && w_waiting && (r_wait_cnt == CNT_W'(MEM_TIMEOUT));
  assign w_imm        = (op_code[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_wait_cnt  <= '0;
      r_wr_pc_src <= PC_SRC_INC;
    end else begin
      r_state <= w_next;
      // Wait states are never adjacent, so clearing on every non-waiting
      // cycle guarantees a zero count on entry to each access.
      if (w_waiting) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      else           r_wait_cnt <= '0;
      // WRITE's pc_src is chosen one state early by JAL/JCOND and
      // falls back to PC+1 once WRITE retires.
      case (r_state)
        S_JAL:   r_wr_pc_src <= PC_SRC_REG;
        S_JCOND: r_wr_pc_src <= w_taken ? PC_SRC_REG : PC_SRC_INC;
        S_WRITE: r_wr_pc_src <= PC_SRC_INC;
        default: r_wr_pc_src <= r_wr_pc_src;
      endcase
    end
  end

  // Instruction decode in priority order; falling through to WRITE
  // marks the opcode as illegal.
  always_comb begin
    w_exec_next = S_WRITE;
    if (op_code == OP_LSH)                                    w_exec_next = S_LSH;
    else if (op_code == OP_LUI)                               w_exec_next = S_LUI;
    else if (op_code == OP_BCOND)                             w_exec_next = S_BCOND;
    else if (op_code == OP_MEM && ext_op_code == EXT_LOAD)    w_exec_next = S_LOAD;
    else if (op_code == OP_MEM && ext_op_code == EXT_STORE)   w_exec_next = S_STORE;
    else if (op_code == OP_MEM && ext_op_code == EXT_JAL)     w_exec_next = S_JAL;
    else if (op_code == OP_MEM && ext_op_code == EXT_JCOND)   w_exec_next = S_JCOND;
    else if (op_code == OP_RTYPE || w_imm)                    w_exec_next = S_ALU;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   if (mem_ready) w_next = S_DECODE; else if (w_timeout) w_next = S_HALT;
      S_DECODE:  w_next = S_EXEC;
      S_EXEC:    w_next = w_exec_next;
      S_LOAD:    if (mem_ready) w_next = S_LOAD_WB; else if (w_timeout) w_next = S_HALT;
      S_STORE:   if (mem_ready) w_next = S_WRITE; else if (w_timeout) w_next = S_HALT;
      S_ALU, S_LSH, S_LUI, S_LOAD_WB, S_JAL, S_JCOND: w_next = S_WRITE;
      S_BCOND, S_WRITE: w_next = S_FETCH;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req         = 1'b0;
    write_to_memory = 1'b0;
    loading         = 1'b0;
    storing         = 1'b0;
    instruction_en  = 1'b0;
    alu_A_src       = 1'b0;
    alu_B_src       = 1'b0;
    alu_cont        = '0;
    reg_write       = 1'b0;
    reg_write_src   = RWS_ALU;
    pc_en           = 1'b0;
    pc_src          = PC_SRC_ALU;
    illegal         = 1'b0;
    halted          = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH:  mem_req = 1'b1;
        S_DECODE: instruction_en = 1'b1;
        S_EXEC:   illegal = (w_exec_next == S_WRITE);
        S_ALU: begin
          alu_A_src = 1'b1;
          alu_B_src = w_imm;
          alu_cont  = ALU_CONT_BITS'({2'b00, (w_imm ? op_code : ext_op_code)});
          reg_write = !(op_code == OP_CMP || ext_op_code == OP_CMP);
        end
        S_LSH: begin
          alu_A_src = 1'b1;
          alu_B_src = 1'b1;
          alu_cont  = ALU_CONT_BITS'({2'b10, op_code});
          reg_write = 1'b1;
        end
        S_LUI: begin
          alu_A_src = 1'b1;
          alu_B_src = 1'b1;
          alu_cont  = '1;
          reg_write = 1'b1;
        end
        S_LOAD: begin
          mem_req = 1'b1;
          loading = 1'b1;
        end
        S_LOAD_WB: begin
          reg_write     = 1'b1;
          reg_write_src = RWS_MEM;
        end
        S_STORE: begin
          mem_req         = 1'b1;
          write_to_memory = 1'b1;
          storing         = 1'b1;
        end
        S_JAL: begin
          reg_write     = 1'b1;
          reg_write_src = RWS_PC1;
        end
        S_BCOND: begin
          pc_en     = 1'b1;
          alu_B_src = 1'b1;
          alu_cont  = ALU_CONT_BITS'({2'b11, op_code});
          pc_src    = w_taken ? PC_SRC_ALU : PC_SRC_INC;
        end
        S_WRITE: begin
          pc_en  = 1'b1;
          pc_src = r_wr_pc_src;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
